gpioemu_axes: RTL and testbench

//  Parametrised successor of the GPIO emulator: NUM_AXES independent AXIS_W-bit output fields and

---
 rtl/gpioemu_axes.sv | 142 ++++++++++++++
 tb/tb_gpioemu_axes.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_axes.sv
// GPIO emulator with NUM_AXES output/latched-input fields on a 12-bit register bus plus countdown timer.
// Define GPIOEMU_AUTORELOAD_EN for a periodic timer; otherwise the timer is one-shot.
module gpioemu_axes #(
    parameter int unsigned      NUM_AXES    = 2,
    parameter int unsigned      AXIS_W      = 4,
    parameter int unsigned      AXIS_LSB    = 9,
    parameter int unsigned      AXIS_STRIDE = 12,
    parameter logic [11:0]      BASE_ADDR   = 12'h210,
    parameter int unsigned      CNT_W       = 8,
    parameter logic [CNT_W-1:0] CNT_INIT    = 'h56
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [11:0]                  saddress,
    input  logic                         srd,
    input  logic                         swr,
    input  logic [31:0]                  sdata_in,
    output logic [31:0]                  sdata_out,
    input  logic [NUM_AXES*AXIS_W-1:0]   gpio_in,
    input  logic                         gpio_latch,
    output logic [NUM_AXES*AXIS_W-1:0]   gpio_out,
    output logic [31:0]                  gpio_in_s_insp,
    output logic                         irq
);

    localparam int unsigned G            = NUM_AXES * AXIS_W;
    localparam logic [11:0] TSTAT_ADDR   = BASE_ADDR + 12'(4 * NUM_AXES);
    localparam logic [11:0] TRELOAD_ADDR = TSTAT_ADDR + 12'd4;
    localparam logic [31:0] ACK_CODE     = 32'h20;

    logic             srd_q, swr_q, latch_q;
    logic [G-1:0]     gpio_out_q, gpio_out_d;
    logic [G-1:0]     gpio_in_s_q, gpio_in_s_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             irq_q, irq_d;
    logic [31:0]      sdata_out_q, sdata_out_d;

    logic                rd_ev, wr_ev, latch_ev;
    logic [NUM_AXES-1:0] axis_hit;
    logic                tstat_hit, treload_hit, ack;
    logic [31:0]         rd_data;

    // Strobes act only on their sampled rising edge, so a held strobe is a single event.
    always_comb begin
        rd_ev    = srd & ~srd_q;
        wr_ev    = swr & ~swr_q;
        latch_ev = gpio_latch & ~latch_q;
    end

    always_comb begin
        axis_hit = '0;
        for (int unsigned k = 0; k < NUM_AXES; k++) begin
            axis_hit[k] = (saddress == (BASE_ADDR + 12'(4 * k)));
        end
        tstat_hit   = (saddress == TSTAT_ADDR);
        treload_hit = (saddress == TRELOAD_ADDR);
        ack         = wr_ev & tstat_hit & (sdata_in == ACK_CODE);
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (wr_ev) begin
            for (int unsigned k = 0; k < NUM_AXES; k++) begin
                if (axis_hit[k]) begin
                    gpio_out_d[k*AXIS_W +: AXIS_W] = sdata_in[AXIS_LSB + k*AXIS_STRIDE +: AXIS_W];
                end
            end
        end
    end

    always_comb begin
        gpio_in_s_d = latch_ev ? gpio_in : gpio_in_s_q;
    end

    // Read data is built from pre-edge state, so a coincident write is not visible.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_AXES; k++) begin
            if (axis_hit[k]) begin
                rd_data[AXIS_LSB + k*AXIS_STRIDE +: AXIS_W] = gpio_in_s_q[k*AXIS_W +: AXIS_W];
            end
        end
        if (tstat_hit) begin
            rd_data[5]          = irq_q;
            rd_data[8 +: CNT_W] = counter_q;
        end
        if (treload_hit) begin
            rd_data[CNT_W-1:0] = reload_q;
        end
        sdata_out_d = rd_ev ? rd_data : sdata_out_q;
    end

    always_comb begin
        reload_d  = (wr_ev & treload_hit) ? sdata_in[CNT_W-1:0] : reload_q;
        counter_d = counter_q;
        irq_d     = irq_q;
        if (ack) begin
            irq_d     = 1'b0;
            counter_d = reload_q;
        end else if (counter_q != '0) begin
            counter_d = counter_q - CNT_W'(1);
        end else begin
            irq_d = 1'b1;
`ifdef GPIOEMU_AUTORELOAD_EN
            counter_d = reload_q;
`else
            counter_d = counter_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            latch_q     <= 1'b0;
            gpio_out_q  <= '0;
            gpio_in_s_q <= '0;
            counter_q   <= CNT_INIT;
            reload_q    <= CNT_INIT;
            irq_q       <= 1'b0;
            sdata_out_q <= '0;
        end else begin
            srd_q       <= srd;
            swr_q       <= swr;
            latch_q     <= gpio_latch;
            gpio_out_q  <= gpio_out_d;
            gpio_in_s_q <= gpio_in_s_d;
            counter_q   <= counter_d;
            reload_q    <= reload_d;
            irq_q       <= irq_d;
            sdata_out_q <= sdata_out_d;
        end
    end

    assign sdata_out      = sdata_out_q;
    assign gpio_out       = gpio_out_q;
    assign gpio_in_s_insp = 32'(gpio_in_s_q);
    assign irq            = irq_q;

endmodule

// File: tb/tb_gpioemu_axes.sv
// Scoreboard bench for gpioemu_axes with default parameters; read results are predicted by a
// behavioural model of the register map and timer driven from the bench's own stimulus.
module tb_gpioemu_axes;

    localparam logic [11:0] A0      = 12'h210;
    localparam logic [11:0] A1      = 12'h214;
    localparam logic [11:0] TSTAT   = 12'h218;
    localparam logic [11:0] TRELOAD = 12'h21C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic [7:0]  gpio_in = '0;
    logic        gpio_latch = 1'b0;
    logic [7:0]  gpio_out;
    logic [31:0] insp;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] first;
    int guard;

    gpioemu_axes dut (
        .clk            (clk),
        .reset          (reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (insp),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Reference model
    logic       m_srd_q, m_swr_q, m_lat_q, m_irq;
    logic [7:0] m_out, m_ins, m_cnt, m_rel;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_srd_q <= 1'b0; m_swr_q <= 1'b0; m_lat_q <= 1'b0; m_irq <= 1'b0;
            m_out <= 8'h00; m_ins <= 8'h00; m_cnt <= 8'h56; m_rel <= 8'h56;
        end else begin
            m_srd_q <= srd;
            m_swr_q <= swr;
            m_lat_q <= gpio_latch;
            if (swr && !m_swr_q) begin
                if (saddress == A0) m_out[3:0] <= sdata_in[12:9];
                if (saddress == A1) m_out[7:4] <= sdata_in[24:21];
                if (saddress == TRELOAD) m_rel <= sdata_in[7:0];
            end
            if (gpio_latch && !m_lat_q) m_ins <= gpio_in;
            if (swr && !m_swr_q && saddress == TSTAT && sdata_in == 32'h20) begin
                m_irq <= 1'b0;
                m_cnt <= m_rel;
            end else if (m_cnt != 8'h00) begin
                m_cnt <= m_cnt - 8'h01;
            end else begin
                m_irq <= 1'b1;
`ifdef GPIOEMU_AUTORELOAD_EN
                m_cnt <= m_rel;
`endif
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            A0:      return {19'b0, m_ins[3:0], 9'b0};
            A1:      return {7'b0, m_ins[7:4], 21'b0};
            TSTAT:   return {16'b0, m_cnt, 2'b0, m_irq, 5'b0};
            TRELOAD: return {24'b0, m_rel};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            exp = sb_q.pop_front();
            check_eq(tag, sdata_out, exp);
        end
    endtask

    // Called at a negedge; idles one cycle so the strobe is seen low before its rise.
    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        saddress = a;
        sdata_in = d;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, input string tag);
        @(negedge clk);
        saddress = a;
        srd = 1'b1;
        sb_q.push_back(m_read(a));
        @(negedge clk);
        srd = 1'b0;
        pop_check(tag);
    endtask

    // Releases reset and reads TSTAT on the very first edge.
    task automatic release_and_read(input string tag);
        @(negedge clk);
        reset = 1'b0;
        saddress = TSTAT;
        srd = 1'b1;
        sb_q.push_back(m_read(TSTAT));
        @(negedge clk);
        srd = 1'b0;
        pop_check(tag);
        check_eq({tag, "_const"}, sdata_out, 32'h0000_5600);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_sdata_out", sdata_out, 32'h0);
        check_eq("rst_gpio_out", 32'(gpio_out), 32'h0);
        check_eq("rst_insp", insp, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);

        // Timer from reset: irq rises on the 87th edge
        release_and_read("tstat_pre");
        repeat (85) @(negedge clk);
        check_eq("irq_edge86", 32'(irq), 32'h0);
        @(negedge clk);
        check_eq("irq_edge87", 32'(irq), 32'h1);
        bus_read(TSTAT, "tstat_post");
`ifndef GPIOEMU_AUTORELOAD_EN
        check_eq("tstat_post_const", sdata_out, 32'h0000_0020);
`endif

        // Axis writes
        bus_write(A0, 32'h0000_1A00);
        bus_write(A1, 32'h01A0_0000);
        check_eq("gpio_out_dd", 32'(gpio_out), 32'h0000_00DD);

        // Input latch
        @(negedge clk);
        gpio_in = 8'hB7;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in = 8'h00;
        check_eq("insp_b7", insp, 32'h0000_00B7);
        bus_read(A0, "rd_axis0");
        check_eq("rd_axis0_const", sdata_out, 32'h0000_0E00);
        bus_read(A1, "rd_axis1");
        check_eq("rd_axis1_const", sdata_out, 32'h0160_0000);

        // Reload 5 then ack: irq sets 6 edges later
        bus_write(TRELOAD, 32'h5);
        bus_write(TSTAT, 32'h20);
        check_eq("ack_clr", 32'(irq), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("irq_counting", 32'(irq), 32'h0);
        end
        @(negedge clk);
        check_eq("irq_after6", 32'(irq), 32'h1);
        bus_write(TSTAT, 32'h21);
        check_eq("bad_ack_ignored", 32'(irq), 32'h1);

        // Same-edge read and write of TRELOAD returns the old value
        @(negedge clk);
        saddress = TRELOAD;
        sdata_in = 32'h9;
        srd = 1'b1;
        swr = 1'b1;
        sb_q.push_back(m_read(TRELOAD));
        @(negedge clk);
        srd = 1'b0;
        swr = 1'b0;
        pop_check("rw_same_edge");
        check_eq("rw_same_edge_const", sdata_out, 32'h5);
        bus_read(TRELOAD, "reload_new");

        // Unmapped accesses
        bus_write(12'h300, 32'hFFFF_FFFF);
        check_eq("unmapped_wr_gpio", 32'(gpio_out), 32'h0000_00DD);
        bus_read(TRELOAD, "unmapped_wr_reload");
        bus_read(12'h300, "unmapped_rd");
        check_eq("unmapped_rd_const", sdata_out, 32'h0);

        // Ack coinciding with decrement to zero
        bus_write(TSTAT, 32'h20);
        guard = 0;
        while (m_cnt != 8'h01 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("wait_cnt1_timeout", 32'(guard < 50), 32'h1);
        saddress = TSTAT;
        sdata_in = 32'h20;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        check_eq("ack_vs_dec_irq", 32'(irq), 32'h0);
        bus_read(TSTAT, "ack_vs_dec_tstat");

        // Ack coinciding with zero-detect
        guard = 0;
        while (m_cnt != 8'h00 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("wait_cnt0_timeout", 32'(guard < 50), 32'h1);
        saddress = TSTAT;
        sdata_in = 32'h20;
        swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
        check_eq("ack_vs_zero_irq", 32'(irq), 32'h0);
        bus_read(TSTAT, "ack_vs_zero_tstat");

        // Reload 0: irq on the edge after ack
        bus_write(TRELOAD, 32'h0);
        bus_write(TSTAT, 32'h20);
        check_eq("rel0_ack", 32'(irq), 32'h0);
        @(negedge clk);
        check_eq("rel0_next", 32'(irq), 32'h1);

        // Held read strobe: only one read happens while the counter keeps moving
        bus_write(TRELOAD, 32'h7);
        bus_write(TSTAT, 32'h20);
        @(negedge clk);
        saddress = TSTAT;
        srd = 1'b1;
        first = m_read(TSTAT);
        sb_q.push_back(first);
        @(negedge clk);
        pop_check("hold_first");
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq("hold_no_reread", sdata_out, first);
        end
        srd = 1'b0;

        // Reload 3: periodic or one-shot depending on build
        bus_write(TRELOAD, 32'h3);
        bus_write(TSTAT, 32'h20);
        for (int i = 0; i < 6; i++) begin
            bus_read(TSTAT, "period_tstat");
        end

        // Asynchronous reset mid-count
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("async_rst_irq", 32'(irq), 32'h0);
        check_eq("async_rst_gpio", 32'(gpio_out), 32'h0);
        check_eq("async_rst_insp", insp, 32'h0);
        check_eq("async_rst_sdata", sdata_out, 32'h0);
        release_and_read("tstat_after_rst");
        bus_read(TRELOAD, "reload_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
